// File: rtl/sram_1p_be.sv
// Single-port synchronous RAM with byte-lane write enables, registered read data,
// a valid/ready request port and an optional post-reset zero-fill sequencer.
module sram_1p_be #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 7,
    parameter bit          OUT_REG        = 1'b0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                init_done
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                init_done_q, init_done_d;
    logic                s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]   s1_data_q, s1_data_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                rd_accept;
    logic [DATA_W-1:0]   rd_word;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [BE_W-1:0]     wr_be;

    assign accept    = req_valid & req_ready_q;
    assign rd_accept = accept & ~req_we;
    assign rd_word   = mem[req_addr];

    // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (&clr_cnt_q) begin
                state_d = ST_RUN;
            end
        end
        req_ready_d = (state_d == ST_RUN);
        init_done_d = (state_d == ST_RUN);
    end

    // The clear sequencer owns the single write port until the array is zeroed.
    always_comb begin
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt_q;
            wr_data = '0;
            wr_be   = '1;
        end else begin
            wr_en   = accept & req_we;
            wr_addr = req_addr;
            wr_data = req_wdata;
            wr_be   = req_be;
        end
    end

    always_comb begin
        s1_valid_d = rd_accept;
        s1_data_d  = rd_accept ? rd_word : s1_data_q;
        if (OUT_REG) begin
            rsp_valid_d = s1_valid_q;
            rsp_rdata_d = s1_valid_q ? s1_data_q : rsp_rdata_q;
        end else begin
            rsp_valid_d = rd_accept;
            rsp_rdata_d = rd_accept ? rd_word : rsp_rdata_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_q   <= '0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            req_ready_q <= req_ready_d;
            init_done_q <= init_done_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // NOTE: the storage array has no reset so it maps onto plain RAM; zeroing is the sequencer's job.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (wr_en && wr_be[i]) begin
                mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign init_done = init_done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_1p_be.sv
// Bench for sram_1p_be: two cleared 16-word instances (OUT_REG 0 and 1) sharing stimulus,
// plus a 128-word no-clear instance, all checked every cycle against an array/queue model.
module tb_sram_1p_be;

    logic        clk;
    logic        rst;

    logic        req_valid, req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        a_ready, a_valid, a_init;
    logic [31:0] a_rdata;
    logic        b_ready, b_valid, b_init;
    logic [31:0] b_rdata;

    logic        c_req_valid, c_req_we;
    logic [6:0]  c_req_addr;
    logic [31:0] c_req_wdata;
    logic [3:0]  c_req_be;
    logic        c_ready, c_valid, c_init;
    logic [31:0] c_rdata;

    sram_1p_be #(.DATA_W(32), .ADDR_W(4), .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1)) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(a_valid), .rsp_rdata(a_rdata), .init_done(a_init));

    sram_1p_be #(.DATA_W(32), .ADDR_W(4), .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b1)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(b_valid), .rsp_rdata(b_rdata), .init_done(b_init));

    sram_1p_be #(.DATA_W(32), .ADDR_W(7), .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b0)) u_c (
        .clk(clk), .rst(rst), .req_valid(c_req_valid), .req_ready(c_ready), .req_we(c_req_we),
        .req_addr(c_req_addr), .req_wdata(c_req_wdata), .req_be(c_req_be),
        .rsp_valid(c_valid), .rsp_rdata(c_rdata), .init_done(c_init));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    int          n_checks;
    int          n_fail;
    int          cyc;
    int          clr_left;
    bit          c_up;
    logic [31:0] mem_m [16];
    logic [31:0] mem_c [128];
    bit          known [128];
    int          known_q [$];
    rsp_t        q_a [$];
    rsp_t        q_b [$];
    rsp_t        q_c [$];
    logic [31:0] last_r [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    // Reset wipes the pipelines; the cleared arrays end up all-zero, the no-clear array keeps its contents.
    task automatic model_reset();
        clr_left = 16;
        c_up     = 1'b0;
        q_a.delete();
        q_b.delete();
        q_c.delete();
        for (int i = 0; i < 3; i++) last_r[i] = '0;
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
    endtask

    task automatic check_port(input int k, input string tag, input logic v, input logic [31:0] d);
        rsp_t e;
        bit   exp_v;
        exp_v = 1'b0;
        e     = '{due: 0, data: '0};
        case (k)
            0: if (q_a.size() > 0 && q_a[0].due == cyc) begin e = q_a.pop_front(); exp_v = 1'b1; end
            1: if (q_b.size() > 0 && q_b[0].due == cyc) begin e = q_b.pop_front(); exp_v = 1'b1; end
            default: if (q_c.size() > 0 && q_c[0].due == cyc) begin e = q_c.pop_front(); exp_v = 1'b1; end
        endcase
        if (exp_v) last_r[k] = e.data;
        check({tag, "_valid"}, 32'(v), 32'(exp_v));
        check({tag, "_rdata"}, d, last_r[k]);
    endtask

    // One clock: update the model at the rising edge, compare all outputs at the falling edge.
    task automatic tick(input bit rst_after = 1'b0);
        rsp_t e;
        int   ca;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            if (clr_left > 0) begin
                clr_left--;
            end else if (req_valid) begin
                if (req_we) begin
                    mem_m[req_addr] = merge(mem_m[req_addr], req_wdata, req_be);
                end else begin
                    e.data = mem_m[req_addr];
                    e.due  = cyc;
                    q_a.push_back(e);
                    e.due  = cyc + 1;
                    q_b.push_back(e);
                end
            end
            if (c_up && c_req_valid) begin
                ca = int'(c_req_addr);
                if (c_req_we) begin
                    if (known[ca]) begin
                        mem_c[ca] = merge(mem_c[ca], c_req_wdata, c_req_be);
                    end else if (c_req_be == 4'hF) begin
                        mem_c[ca] = c_req_wdata;
                        known[ca] = 1'b1;
                        known_q.push_back(ca);
                    end
                end else begin
                    e.data = mem_c[ca];
                    e.due  = cyc;
                    q_c.push_back(e);
                end
            end
            c_up = 1'b1;
        end
        if (rst_after) begin
            #1;
            rst = 1'b1;
            model_reset();
        end
        @(negedge clk);
        check("a_ready", 32'(a_ready), 32'(clr_left == 0));
        check("a_init",  32'(a_init),  32'(clr_left == 0));
        check("b_ready", 32'(b_ready), 32'(clr_left == 0));
        check("b_init",  32'(b_init),  32'(clr_left == 0));
        check("c_ready", 32'(c_ready), 32'(c_up));
        check("c_init",  32'(c_init),  32'(c_up));
        check_port(0, "a", a_valid, a_rdata);
        check_port(1, "b", b_valid, b_rdata);
        check_port(2, "c", c_valid, c_rdata);
    endtask

    task automatic drive_a(input bit v, input bit we, input int addr, input logic [31:0] wd,
                           input logic [3:0] be);
        req_valid = v;
        req_we    = we;
        req_addr  = 4'(addr);
        req_wdata = wd;
        req_be    = be;
    endtask

    task automatic drive_c(input bit v, input bit we, input int addr, input logic [31:0] wd,
                           input logic [3:0] be);
        c_req_valid = v;
        c_req_we    = we;
        c_req_addr  = 7'(addr);
        c_req_wdata = wd;
        c_req_be    = be;
    endtask

    task automatic garbage_a();
        drive_a(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, 4'($urandom));
    endtask

    task automatic wait_clear();
        for (int i = 0; i < 40 && clr_left > 0; i++) begin
            garbage_a();
            tick();
        end
        drive_a(1'b0, 1'b0, 0, '0, '0);
    endtask

    task automatic reset_pulse();
        drive_a(1'b0, 1'b0, 0, '0, '0);
        drive_c(1'b0, 1'b0, 0, '0, '0);
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic random_ops(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) drive_a(1'b0, 1'b0, 0, '0, '0);
            else drive_a(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, 4'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                drive_c(1'b0, 1'b0, 0, '0, '0);
            end else if (known_q.size() == 0 || $urandom_range(0, 1) == 0) begin
                drive_c(1'b1, 1'b1, $urandom_range(0, 127), $urandom,
                        ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom));
            end else begin
                drive_c(1'b1, 1'b0, known_q[$urandom_range(0, known_q.size() - 1)], '0, '0);
            end
            tick();
        end
        drive_a(1'b0, 1'b0, 0, '0, '0);
        drive_c(1'b0, 1'b0, 0, '0, '0);
    endtask

    initial begin
        logic [31:0] wd_7f;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b0;
        for (int i = 0; i < 128; i++) begin
            known[i] = 1'b0;
            mem_c[i] = '0;
        end
        drive_a(1'b0, 1'b0, 0, '0, '0);
        drive_c(1'b0, 1'b0, 0, '0, '0);
        model_reset();

        #2 rst = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;

        // No-clear instance is usable right after the first edge; cleared ones ignore traffic meanwhile.
        garbage_a();
        tick();
        wd_7f = $urandom;
        drive_c(1'b1, 1'b1, 'h7F, wd_7f, 4'hF);
        garbage_a();
        tick();
        drive_c(1'b1, 1'b0, 'h7F, '0, '0);
        garbage_a();
        tick();
        check("c_imm_7f", c_rdata, wd_7f);
        drive_c(1'b0, 1'b0, 0, '0, '0);
        wait_clear();

        for (int n = 0; n < 16; n++) begin
            drive_a(1'b1, 1'b0, n, '0, '0);
            tick();
        end
        drive_a(1'b0, 1'b0, 0, '0, '0);
        tick();
        tick();

        drive_a(1'b1, 1'b1, 3, 32'hAABBCCDD, 4'hF);
        tick();
        drive_a(1'b1, 1'b1, 3, 32'h11223344, 4'h5);
        tick();
        drive_a(1'b1, 1'b0, 3, '0, '0);
        tick();
        check("be_merge_a", a_rdata, 32'hAA22CC44);
        drive_a(1'b0, 1'b0, 0, '0, '0);
        tick();
        check("be_merge_b", b_rdata, 32'hAA22CC44);

        for (int n = 0; n < 16; n++) begin
            drive_a(1'b1, 1'b1, n, 32'(n) * 32'h01010101, 4'hF);
            tick();
        end
        for (int n = 0; n < 16; n++) begin
            drive_a(1'b1, 1'b0, n, $urandom, 4'($urandom));
            tick();
        end
        drive_a(1'b0, 1'b0, 0, '0, '0);
        tick();
        tick();
        tick();
        check("stream_hold_a", a_rdata, 32'h0F0F0F0F);
        check("stream_hold_b", b_rdata, 32'h0F0F0F0F);

        drive_a(1'b1, 1'b1, 5, 32'h1, 4'hF);
        tick();
        drive_a(1'b1, 1'b0, 5, '0, '0);
        tick();
        check("rd_before_wr", a_rdata, 32'h1);
        drive_a(1'b1, 1'b1, 5, 32'h2, 4'hF);
        tick();
        drive_a(1'b1, 1'b1, 5, 32'h3, 4'hF);
        tick();
        drive_a(1'b1, 1'b0, 5, '0, '0);
        tick();
        check("wr_before_rd", a_rdata, 32'h3);
        drive_a(1'b1, 1'b1, 5, 32'hFFFFFFFF, 4'h0);
        tick();
        drive_a(1'b1, 1'b0, 5, '0, '0);
        tick();
        check("be_zero_noop", a_rdata, 32'h3);
        drive_a(1'b0, 1'b0, 0, '0, '0);
        tick();
        tick();

        random_ops(300);

        // Reset again part-way through the clear: the full 16-cycle clear must repeat.
        reset_pulse();
        for (int i = 0; i < 7; i++) begin
            garbage_a();
            tick();
        end
        reset_pulse();
        wait_clear();
        random_ops(60);

        // Reset landing just after a read accept drops the response.
        drive_a(1'b1, 1'b0, 7, '0, '0);
        if (known_q.size() > 0) drive_c(1'b1, 1'b0, known_q[0], '0, '0);
        tick(1'b1);
        drive_a(1'b0, 1'b0, 0, '0, '0);
        drive_c(1'b0, 1'b0, 0, '0, '0);
        tick();
        tick();
        check("flush_a_rdata", a_rdata, 32'h0);
        check("flush_b_rdata", b_rdata, 32'h0);
        rst = 1'b0;
        wait_clear();
        random_ops(150);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
